uart_rx: RTL and testbench

UART receiver, 8N1 by default, sampling asynchronous serial line uart_rxd at mid-bit with a fixed clock divisor. It is the receive-direction counterpart of the existing uart_tx and sits beside it in the top level, fed by a dedicated input pin. Received bytes go into a one-entry holding register with valid/read handshake, overrun flag and framing-error flag, for consumption by a command/echo FSM.

---
 rtl/uart_rx.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// Mid-bit sampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a one-entry holding register.
// Latency: done ~9.5*CLKS_PER_BIT+SYNC_STAGES+1 cycles after start edge; no backpressure, unread byte is overwritten with overrun pulse.
module uart_rx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_clk,
  input  logic       uart_rxd,
  input  logic       uart_rx_read,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_valid,
  output logic       uart_rx_done,
  output logic       uart_rx_frame_err,
  output logic       uart_rx_overrun,
  output logic       uart_rx_parity_err,
  output logic       uart_rx_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxd_s;
  logic                   bit_end;
  logic                   par_bad;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   perr_q, perr_d;
`endif

  assign rxd_s   = sync_q[SYNC_STAGES-1];
  assign bit_end = (cnt_q == CNT_BIT);

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], uart_rxd};
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    par_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif

    if (uart_rx_read) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!rxd_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rxd_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxd_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          par_d   = rxd_s;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          par_bad = (par_q != ^shift_q);
          perr_d  = par_bad;
`endif
          // Leaving mid-stop-bit lets a back-to-back start edge be caught.
          if (rxd_s) begin
            state_d = S_IDLE;
            if (!par_bad) begin
              data_d  = shift_q;
              done_d  = 1'b1;
              ovr_d   = valid_q & ~uart_rx_read;
              valid_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_BREAK: begin
        if (rxd_s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      sync_q  <= '1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign uart_rx_data      = data_q;
  assign uart_rx_valid     = valid_q;
  assign uart_rx_done      = done_q;
  assign uart_rx_frame_err = ferr_q;
  assign uart_rx_overrun   = ovr_q;
  assign uart_rx_busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign uart_rx_parity_err = perr_q;
`else
  assign uart_rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Directed bench for uart_rx: byte scoreboard filled at send time, drained against bytes captured on done pulses.
module tb_uart_rx;

  localparam int CPB  = 87;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_clk = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       uart_rx_read = 1'b0;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic       uart_rx_done;
  logic       uart_rx_frame_err;
  logic       uart_rx_overrun;
  logic       uart_rx_parity_err;
  logic       uart_rx_busy;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk                (clk),
    .rst_clk            (rst_clk),
    .uart_rxd           (uart_rxd),
    .uart_rx_read       (uart_rx_read),
    .uart_rx_data       (uart_rx_data),
    .uart_rx_valid      (uart_rx_valid),
    .uart_rx_done       (uart_rx_done),
    .uart_rx_frame_err  (uart_rx_frame_err),
    .uart_rx_overrun    (uart_rx_overrun),
    .uart_rx_parity_err (uart_rx_parity_err),
    .uart_rx_busy       (uart_rx_busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int got_idx = 0;

  int cyc      = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int perr_cnt = 0;
  logic manual_read = 1'b0;
  logic auto_read   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sole driver of uart_rx_read; records every output pulse.
  always @(negedge clk) begin
    uart_rx_read = manual_read | (auto_read & uart_rx_done);
    if (uart_rx_done) begin
      got_q.push_back(uart_rx_data);
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (uart_rx_frame_err)  ferr_cnt = ferr_cnt + 1;
    if (uart_rx_overrun)    ovr_cnt  = ovr_cnt + 1;
    if (uart_rx_parity_err) perr_cnt = perr_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int got, input int lo, input int hi);
    n_assert++;
    assert (got >= lo && got <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, got, lo, hi);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_bit, input logic stop_bit);
    logic good;
    good = stop_bit;
`ifdef UART_RX_PARITY_EN
    good = good & (par_bit == ^b);
`endif
    if (good) exp_q.push_back(b);
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    uart_rxd = par_bit;
    tick(CPB);
`endif
    uart_rxd = stop_bit;
    tick(CPB);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, ^b, 1'b1);
  endtask

  task automatic drain(input string tag);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_idx < got_q.size()) begin
        chk(tag, got_q[got_idx], e);
        got_idx++;
      end else begin
        chk({tag, "_missing_done"}, got_q.size(), got_idx + 1);
      end
    end
    chk({tag, "_extra_done"}, got_q.size(), got_idx);
  endtask

  task automatic do_read();
    manual_read = 1'b1;
    tick(1);
    manual_read = 1'b0;
    tick(2);
  endtask

  logic [7:0] msg [11] = '{8'h42, 8'h61, 8'h70, 8'h74, 8'h69, 8'h73, 8'h74, 8'h65, 8'h20, 8'h21, 8'h0A};

  initial begin
    int d0, f0, o0, p0, t0, busy_n;

    rst_clk  = 1'b1;
    uart_rxd = 1'b1;
    tick(3);
    chk("rst_data",      uart_rx_data,       8'h00);
    chk("rst_valid",     uart_rx_valid,      1'b0);
    chk("rst_done",      uart_rx_done,       1'b0);
    chk("rst_frame_err", uart_rx_frame_err,  1'b0);
    chk("rst_overrun",   uart_rx_overrun,    1'b0);
    chk("rst_parity",    uart_rx_parity_err, 1'b0);
    chk("rst_busy",      uart_rx_busy,       1'b0);
    rst_clk = 1'b0;
    tick(5);

    // Single byte with latency check.
    d0 = done_cnt;
    t0 = cyc;
    send_good(8'h42);
    tick(CPB);
    chk("b42_done_cnt", done_cnt - d0, 1);
    chk_rng("b42_latency", done_cyc - t0, 829, 830);
    chk("b42_data", uart_rx_data, 8'h42);
    chk("b42_valid", uart_rx_valid, 1'b1);
    drain("b42_sb");
    do_read();
    chk("b42_valid_after_read", uart_rx_valid, 1'b0);

    // Back-to-back string, read on each done.
    auto_read = 1'b1;
    d0 = done_cnt; f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
    for (int i = 0; i < 11; i++) send_good(msg[i]);
    tick(CPB);
    chk("str_done_cnt", done_cnt - d0, 11);
    chk("str_ferr", ferr_cnt - f0, 0);
    chk("str_ovr", ovr_cnt - o0, 0);
    chk("str_perr", perr_cnt - p0, 0);
    drain("str_sb");
    chk("str_valid", uart_rx_valid, 1'b0);
    auto_read = 1'b0;

    // Short low glitch on idle line.
    d0 = done_cnt; f0 = ferr_cnt;
    busy_n = 0;
    uart_rxd = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 20) uart_rxd = 1'b1;
      tick(1);
      busy_n += int'(uart_rx_busy);
    end
    chk_rng("glitch_busy_cycles", busy_n, 40, 45);
    chk("glitch_done", done_cnt - d0, 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    send_good(8'h55);
    tick(CPB);
    chk("b55_done_cnt", done_cnt - d0, 1);
    chk("b55_data", uart_rx_data, 8'h55);
    drain("b55_sb");
    do_read();

    // Bad stop bit followed by a long break.
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, ^(8'hA5), 1'b0);
    tick(2000);
    chk("brk_ferr_cnt", ferr_cnt - f0, 1);
    chk("brk_done", done_cnt - d0, 0);
    chk("brk_valid", uart_rx_valid, 1'b0);
    chk("brk_busy", uart_rx_busy, 1'b1);
    uart_rxd = 1'b1;
    tick(CPB);
    chk("brk_idle_busy", uart_rx_busy, 1'b0);
    send_good(8'h3C);
    tick(CPB);
    chk("b3c_done_cnt", done_cnt - d0, 1);
    chk("b3c_ferr_total", ferr_cnt - f0, 1);
    chk("b3c_data", uart_rx_data, 8'h3C);
    drain("b3c_sb");
    do_read();

    // Overrun: two bytes, no read.
    d0 = done_cnt; o0 = ovr_cnt;
    send_good(8'h11);
    chk("ovr_first_none", ovr_cnt - o0, 0);
    send_good(8'h22);
    tick(CPB);
    chk("ovr_cnt", ovr_cnt - o0, 1);
    chk("ovr_done_cnt", done_cnt - d0, 2);
    chk("ovr_data", uart_rx_data, 8'h22);
    chk("ovr_valid", uart_rx_valid, 1'b1);
    drain("ovr_sb");
    do_read();
    chk("ovr_valid_after_read", uart_rx_valid, 1'b0);
    do_read();
    chk("read_when_empty", uart_rx_valid, 1'b0);

`ifdef UART_RX_PARITY_EN
    d0 = done_cnt; p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    tick(CPB);
    chk("par_good_done", done_cnt - d0, 1);
    chk("par_good_data", uart_rx_data, 8'h07);
    chk("par_good_perr", perr_cnt - p0, 0);
    drain("par_good_sb");
    do_read();
    send_frame(8'h07, 1'b0, 1'b1);
    tick(CPB);
    chk("par_bad_perr", perr_cnt - p0, 1);
    chk("par_bad_done", done_cnt - d0, 1);
    chk("par_bad_valid", uart_rx_valid, 1'b0);
    drain("par_bad_sb");
`endif

    // Reset in the middle of the data bits.
    d0 = done_cnt; f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
    uart_rxd = 1'b0;
    tick(CPB);
    uart_rxd = 1'b1; tick(CPB);
    uart_rxd = 1'b0; tick(CPB);
    uart_rxd = 1'b1; tick(CPB / 2);
    chk("mid_busy", uart_rx_busy, 1'b1);
    rst_clk = 1'b1;
    #1;
    chk("mid_rst_busy_now", uart_rx_busy, 1'b0);
    chk("mid_rst_data", uart_rx_data, 8'h00);
    tick(1);
    chk("mid_rst_busy_next", uart_rx_busy, 1'b0);
    uart_rxd = 1'b1;
    tick(2);
    rst_clk = 1'b0;
    tick(3 * CPB);
    chk("mid_done", done_cnt - d0, 0);
    chk("mid_ferr", ferr_cnt - f0, 0);
    chk("mid_ovr", ovr_cnt - o0, 0);
    chk("mid_perr", perr_cnt - p0, 0);
    chk("mid_valid", uart_rx_valid, 1'b0);
    chk("mid_busy_after", uart_rx_busy, 1'b0);
    drain("mid_sb");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
